// File: rtl/io_function_sequencer_pkg.sv
// Shared definitions for the IO function sequencer.
// Holds the register word indices, the bit position of each peripheral
// function in the function-enable vector, the CTRL register bit positions
// and the state encoding of the sequencing FSM.
package io_function_sequencer_pkg;

    // Register word indices on the peripheral bus
    localparam logic [1:0] REG_FUNC_REQ    = 2'd0;
    localparam logic [1:0] REG_FUNC_ACTIVE = 2'd1;
    localparam logic [1:0] REG_GUARD       = 2'd2;
    localparam logic [1:0] REG_CTRL        = 2'd3;

    // Function-enable bit positions
    localparam int FN_IRQ    = 0;
    localparam int FN_UART2  = 1;
    localparam int FN_UART3  = 2;
    localparam int FN_SPI0   = 3;
    localparam int FN_PWM0   = 4;
    localparam int PWM_COUNT = 8;

    // CTRL register bit positions
    localparam int CTRL_LOCK        = 0;
    localparam int CTRL_DONE_IRQ_EN = 1;
    localparam int CTRL_BUSY        = 8;
    localparam int CTRL_DONE_FLAG   = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PARK    = 2'd1,
        ST_APPLY   = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/io_function_sequencer_if.sv
// Register-access bus of the IO function sequencer.
//   bus_en    : single-cycle access strobe
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : register word index 0..3
//   bus_wdata : write data
//   bus_rdata : read data, valid the cycle after a read strobe
// master = bus initiator (CPU side), slave = the sequencer.
interface io_function_sequencer_if;
    logic        bus_en;
    logic        bus_we;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_en,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_en,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/io_function_guard_timer.sv
// Loadable down-counter used to time the park (guard) phase.
//   clk, rst   : clock, synchronous active-high reset
//   load       : load count with load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one (saturates at zero)
//   expire     : high while the count equals one, i.e. on the last
//                cycle of the guard interval
module io_function_guard_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             expire
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign expire = (count_reg == WIDTH'(1));

endmodule

// File: rtl/io_function_sequencer.sv
// IO function sequencer: owns the peripheral-enable inputs of the IO
// multiplexer and applies a new function set break-before-make. Pins whose
// function changes are parked as inputs for a programmable guard time, the
// new enables are applied, then the pins are released.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : register interface (slave modport)
//   irq_en, uart_en[3:2], spi_en, pwm_en[7:0] : peripheral enables
//   park      : per function bit, forces the pin group to input
//   done_irq  : level interrupt, done_flag & done_irq_en
module io_function_sequencer
    import io_function_sequencer_pkg::*;
#(
    parameter int FUNC_COUNT    = 12,
    parameter int GUARD_WIDTH   = 8,
    parameter int GUARD_DEFAULT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    io_function_sequencer_if.slave bus,
    output logic                  irq_en,
    output logic [3:2]            uart_en,
    output logic                  spi_en,
    output logic [7:0]            pwm_en,
    output logic [FUNC_COUNT-1:0] park,
    output logic                  done_irq
);

    logic [FUNC_COUNT-1:0]  func_req_reg;
    logic [FUNC_COUNT-1:0]  func_active_reg;
    logic [FUNC_COUNT-1:0]  target_reg;
    logic [FUNC_COUNT-1:0]  changed_reg;
    logic [GUARD_WIDTH-1:0] guard_reg;
    logic                   lock_reg;
    logic                   done_irq_en_reg;
    logic                   done_flag_reg;
    logic [31:0]            rdata_reg;
    logic [31:0]            rdata_next;
    seq_state_t             state_reg;
    seq_state_t             state_next;

    logic                   timer_load;
    logic                   timer_dec;
    logic                   timer_expire;
    logic                   seq_start;
    logic                   seq_apply;
    logic                   seq_finish;
    logic [GUARD_WIDTH-1:0] guard_load;
    logic [FUNC_COUNT-1:0]  force_off;
    logic [FUNC_COUNT-1:0]  func_en;

    logic bus_write;
    logic bus_read;
    logic wdata_unused;

    assign bus_write = bus.bus_en & bus.bus_we;
    assign bus_read  = bus.bus_en & ~bus.bus_we;

    // Only some write-data bits have a register behind them.
    assign wdata_unused = ^bus.bus_wdata;

    // A zero guard still parks for one cycle.
    assign guard_load = (guard_reg == '0) ? GUARD_WIDTH'(1) : guard_reg;

    io_function_guard_timer #(
        .WIDTH(GUARD_WIDTH)
    ) u_guard_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (guard_load),
        .dec        (timer_dec),
        .expire     (timer_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        seq_start  = 1'b0;
        seq_apply  = 1'b0;
        seq_finish = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (func_req_reg != func_active_reg) begin
                    seq_start  = 1'b1;
                    timer_load = 1'b1;
                    state_next = ST_PARK;
                end
            end
            ST_PARK: begin
                timer_dec = 1'b1;
                if (timer_expire) begin
                    seq_apply  = 1'b1;
                    state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                seq_finish = 1'b1;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Register file, sequence capture and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            func_req_reg    <= '0;
            func_active_reg <= '0;
            target_reg      <= '0;
            changed_reg     <= '0;
            guard_reg       <= GUARD_WIDTH'(GUARD_DEFAULT);
            lock_reg        <= 1'b0;
            done_irq_en_reg <= 1'b0;
            done_flag_reg   <= 1'b0;
            rdata_reg       <= '0;
        end else begin
            if (bus_write && (bus.bus_addr == REG_FUNC_REQ) && !lock_reg) begin
                func_req_reg <= bus.bus_wdata[FUNC_COUNT-1:0];
            end
            if (bus_write && (bus.bus_addr == REG_GUARD)) begin
                guard_reg <= bus.bus_wdata[GUARD_WIDTH-1:0];
            end
            if (bus_write && (bus.bus_addr == REG_CTRL)) begin
                lock_reg        <= lock_reg | bus.bus_wdata[CTRL_LOCK];
                done_irq_en_reg <= bus.bus_wdata[CTRL_DONE_IRQ_EN];
            end
            // Completion wins over a simultaneous write-1-to-clear.
            if (seq_finish) begin
                done_flag_reg <= 1'b1;
            end else if (bus_write && (bus.bus_addr == REG_CTRL) &&
                         bus.bus_wdata[CTRL_DONE_FLAG]) begin
                done_flag_reg <= 1'b0;
            end
            // Target is frozen for the whole sequence; later requests wait.
            if (seq_start) begin
                target_reg  <= func_req_reg;
                changed_reg <= func_req_reg ^ func_active_reg;
            end
            if (seq_apply) begin
                func_active_reg <= target_reg;
            end
            if (bus_read) begin
                rdata_reg <= rdata_next;
            end
        end
    end

    always_comb begin
        rdata_next = '0;
        case (bus.bus_addr)
            REG_FUNC_REQ:    rdata_next[FUNC_COUNT-1:0]  = func_req_reg;
            REG_FUNC_ACTIVE: rdata_next[FUNC_COUNT-1:0]  = func_active_reg;
            REG_GUARD:       rdata_next[GUARD_WIDTH-1:0] = guard_reg;
            default: begin
                rdata_next[CTRL_LOCK]        = lock_reg;
                rdata_next[CTRL_DONE_IRQ_EN] = done_irq_en_reg;
                rdata_next[CTRL_BUSY]        = (state_reg != ST_IDLE);
                rdata_next[CTRL_DONE_FLAG]   = done_flag_reg;
            end
        endcase
    end

    assign bus.bus_rdata = rdata_reg;

    // Outputs decode straight from registered state so reset clears them at
    // the same edge. Unchanged bits are never masked, so they cannot glitch.
    assign force_off = (state_reg == ST_PARK) ? changed_reg : '0;
    assign func_en   = func_active_reg & ~force_off;
    assign park      = ((state_reg == ST_PARK) || (state_reg == ST_APPLY)) ? changed_reg : '0;
    assign done_irq  = done_flag_reg & done_irq_en_reg;

    assign irq_en  = func_en[FN_IRQ];
    assign uart_en = func_en[FN_UART3:FN_UART2];
    assign spi_en  = func_en[FN_SPI0];

    genvar gi;
    generate
        for (gi = 0; gi < PWM_COUNT; gi++) begin : g_pwm
            assign pwm_en[gi] = func_en[FN_PWM0 + gi];
        end
    endgenerate

endmodule

// File: tb/tb_io_function_sequencer.sv
// Self-checking bench for io_function_sequencer: a register table, hand
// sequences for the multi-cycle cases, and random traffic compared every
// cycle against a timeline model of the break-before-make sequence.
module tb_io_function_sequencer;
    import io_function_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        irq_en;
    logic [3:2]  uart_en;
    logic        spi_en;
    logic [7:0]  pwm_en;
    logic [11:0] park;
    logic        done_irq;

    int n_checks = 0;
    int n_fail   = 0;

    io_function_sequencer_if bus_if ();

    io_function_sequencer #(
        .FUNC_COUNT    (12),
        .GUARD_WIDTH   (8),
        .GUARD_DEFAULT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .irq_en   (irq_en),
        .uart_en  (uart_en),
        .spi_en   (spi_en),
        .pwm_en   (pwm_en),
        .park     (park),
        .done_irq (done_irq)
    );

    always #5 clk = ~clk;

    // Reference model: registers plus the start cycle of the running
    // sequence; phases follow from the offset into that sequence.
    int          cyc = 0;
    logic [11:0] m_req, m_active, m_target, m_changed;
    logic [7:0]  m_guard;
    bit          m_lock, m_irqen, m_done, m_seq;
    int          m_start, m_g;
    logic [31:0] m_rdata;

    typedef struct {
        bit          we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_req = '0; m_active = '0; m_target = '0; m_changed = '0;
        m_guard = 8'd4; m_lock = 0; m_irqen = 0; m_done = 0; m_seq = 0;
        m_start = 0; m_g = 1; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [11:0] req0, act0;
        logic [7:0]  g0;
        logic [31:0] wd;
        bit          lock0, set_now;
        int          off;
        req0 = m_req; act0 = m_active; g0 = m_guard; lock0 = m_lock;
        wd = bus_if.bus_wdata; set_now = 0;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        if (bus_if.bus_en && !bus_if.bus_we) begin
            case (bus_if.bus_addr)
                2'd0: m_rdata = {20'd0, m_req};
                2'd1: m_rdata = {20'd0, m_active};
                2'd2: m_rdata = {24'd0, m_guard};
                default: begin
                    m_rdata = 32'd0;
                    m_rdata[0] = m_lock; m_rdata[1] = m_irqen;
                    m_rdata[8] = m_seq;  m_rdata[9] = m_done;
                end
            endcase
        end
        if (m_seq) begin
            off = cyc - 1 - m_start;
            if (off == m_g - 1) m_active = m_target;
            else if (off == m_g) begin m_done = 1; set_now = 1; end
            else if (off == m_g + 1) m_seq = 0;
        end else if (req0 != act0) begin
            m_seq = 1; m_start = cyc;
            m_g = (g0 == 8'd0) ? 1 : int'(g0);
            m_target = req0; m_changed = req0 ^ act0;
        end
        if (bus_if.bus_en && bus_if.bus_we) begin
            case (bus_if.bus_addr)
                2'd0: if (!lock0) m_req = wd[11:0];
                2'd2: m_guard = wd[7:0];
                2'd3: begin
                    m_lock = m_lock | wd[0];
                    m_irqen = wd[1];
                    if (wd[9] && !set_now) m_done = 0;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        logic [11:0] e_park, e_force;
        int off;
        model_step();
        @(posedge clk);
        @(negedge clk);
        e_park = '0; e_force = '0;
        if (m_seq) begin
            off = cyc - m_start;
            if (off <= m_g) e_park = m_changed;
            if (off < m_g) e_force = m_changed;
        end
        check("model_enables", {pwm_en, spi_en, uart_en, irq_en}, m_active & ~e_force);
        check("model_park", park, e_park);
        check("model_done_irq", done_irq, m_done & m_irqen);
        check("model_rdata", bus_if.bus_rdata, m_rdata);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_if.bus_en = 1; bus_if.bus_we = 1; bus_if.bus_addr = a; bus_if.bus_wdata = d;
        tick();
        bus_if.bus_en = 0; bus_if.bus_we = 0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_if.bus_en = 1; bus_if.bus_we = 0; bus_if.bus_addr = a;
        tick();
        bus_if.bus_en = 0;
        d = bus_if.bus_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        bit saw, glitch, spi_seen, pwm_on_parked;
        int busy_cnt, park_cnt, sel;

        vecs[0]  = '{we:1'b0, addr:2'd1, data:32'd0,          exp:32'd0};
        vecs[1]  = '{we:1'b0, addr:2'd2, data:32'd0,          exp:32'd4};
        vecs[2]  = '{we:1'b0, addr:2'd3, data:32'd0,          exp:32'd0};
        vecs[3]  = '{we:1'b0, addr:2'd0, data:32'd0,          exp:32'd0};
        vecs[4]  = '{we:1'b1, addr:2'd2, data:32'hFFFF_FF07, exp:32'd0};
        vecs[5]  = '{we:1'b0, addr:2'd2, data:32'd0,          exp:32'd7};
        vecs[6]  = '{we:1'b1, addr:2'd1, data:32'h0000_0FFF, exp:32'd0};
        vecs[7]  = '{we:1'b0, addr:2'd1, data:32'd0,          exp:32'd0};
        vecs[8]  = '{we:1'b1, addr:2'd3, data:32'h0000_0002, exp:32'd0};
        vecs[9]  = '{we:1'b0, addr:2'd3, data:32'd0,          exp:32'd2};
        vecs[10] = '{we:1'b1, addr:2'd2, data:32'd4,          exp:32'd0};
        vecs[11] = '{we:1'b1, addr:2'd3, data:32'd0,          exp:32'd0};
        vecs[12] = '{we:1'b0, addr:2'd3, data:32'd0,          exp:32'd0};
        vecs[13] = '{we:1'b0, addr:2'd2, data:32'd0,          exp:32'd4};

        bus_if.bus_en = 0; bus_if.bus_we = 0; bus_if.bus_addr = 0; bus_if.bus_wdata = 0;
        rst = 1;
        model_reset();
        @(negedge clk);
        tick();
        tick();
        rst = 0;
        check("reset_enables", {pwm_en, spi_en, uart_en, irq_en}, 12'h000);
        check("reset_park", park, 12'h000);
        check("reset_done_irq", done_irq, 1'b0);

        // Register table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].data);
                $display("vec %0d: write reg %0d = 0x%0h", i, vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_read", i), rd, vecs[i].exp);
                $display("vec %0d: read reg %0d -> 0x%0h", i, vecs[i].addr, rd);
            end
        end

        // pwm0 enable with GUARD=4: park E1..E5, enable from E5, release E6
        bus_write(2'd0, 32'h010);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("pwm0_park_E%0d", k), park, (k <= 5) ? 12'h010 : 12'h000);
            check($sformatf("pwm0_en_E%0d", k), pwm_en[0], (k >= 5) ? 1'b1 : 1'b0);
        end
        bus_read(2'd3, rd);
        check("pwm0_done_flag", rd[9], 1'b1);
        check("pwm0_busy", rd[8], 1'b0);
        bus_read(2'd1, rd);
        check("pwm0_active", rd, 32'h010);
        $display("seq pwm0: FUNC_ACTIVE=0x%0h", rd);

        // Request changes during PARK: 0x018 completes, then 0x008 follows
        bus_write(2'd0, 32'h018);
        tick();
        tick();
        bus_write(2'd0, 32'h008);
        saw = 0; glitch = 0; spi_seen = 0; pwm_on_parked = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (spi_en) spi_seen = 1;
            else if (spi_seen) glitch = 1;
            if (park == 12'h010) begin
                saw = 1;
                if (pwm_en[0]) pwm_on_parked = 1;
            end
        end
        check("chain_second_park_seen", saw, 1'b1);
        check("chain_spi_no_glitch", glitch, 1'b0);
        check("chain_pwm0_forced_off", pwm_on_parked, 1'b0);
        bus_read(2'd1, rd);
        check("chain_active", rd, 32'h008);
        $display("seq chain: FUNC_ACTIVE=0x%0h", rd);

        // GUARD=0: one PARK cycle, busy for 3 cycles in total
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'h006);
        busy_cnt = 0; park_cnt = 0;
        bus_if.bus_en = 1; bus_if.bus_we = 0; bus_if.bus_addr = 2'd3;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus_if.bus_rdata[8]) busy_cnt++;
            if (park != 12'h000) park_cnt++;
        end
        bus_if.bus_en = 0;
        check("g0_busy_cycles", busy_cnt, 3);
        check("g0_park_cycles", park_cnt, 2);
        bus_read(2'd1, rd);
        check("g0_active", rd, 32'h006);
        $display("seq guard0: busy=%0d park=%0d", busy_cnt, park_cnt);

        // Random traffic against the model
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) bus_write(2'd0, {20'd0, 12'($urandom)});
            else if (sel == 4) bus_write(2'd2, 32'($urandom_range(0, 6)));
            else if (sel == 5) bus_write(2'd3, $urandom & 32'h0000_0202);
            else if (sel == 6) bus_read(2'($urandom_range(0, 3)), rd);
            else repeat ($urandom_range(1, 8)) tick();
            $display("rand op %0d: sel=%0d active=0x%0h park=0x%0h", i, sel,
                     {pwm_en, spi_en, uart_en, irq_en}, park);
        end
        repeat (30) tick();

        // Reset during PARK
        bus_write(2'd2, 32'd4);
        bus_write(2'd0, 32'h00F);
        repeat (12) tick();
        bus_write(2'd0, 32'h0FF);
        tick();
        tick();
        check("prerst_park", park, 12'h0F0);
        check("prerst_enables", {pwm_en, spi_en, uart_en, irq_en}, 12'h00F);
        rst = 1;
        tick();
        check("rst_park", park, 12'h000);
        check("rst_enables", {pwm_en, spi_en, uart_en, irq_en}, 12'h000);
        rst = 0;
        bus_read(2'd3, rd);
        check("rst_busy", rd[8], 1'b0);
        bus_read(2'd1, rd);
        check("rst_active", rd, 32'h000);
        $display("seq reset-in-park: FUNC_ACTIVE=0x%0h", rd);

        // Lock, done interrupt enable and write-1-to-clear
        bus_write(2'd0, 32'h001);
        repeat (10) tick();
        bus_write(2'd3, 32'h001);
        bus_write(2'd0, 32'hFFF);
        repeat (4) tick();
        check("lock_no_park", park, 12'h000);
        bus_read(2'd0, rd);
        check("lock_req", rd, 32'h001);
        bus_write(2'd3, 32'h003);
        check("irq_on", done_irq, 1'b1);
        bus_write(2'd3, 32'h203);
        check("irq_off", done_irq, 1'b0);
        bus_read(2'd3, rd);
        check("lock_ctrl", rd, 32'h003);
        $display("seq lock/irq: CTRL=0x%0h", rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
